// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and helpers for the 8-to-3 request encoder
package enc_pkg;

    localparam int N_IN  = 8;
    localparam int IDX_W = $clog2(N_IN);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/prio_pick8.sv
// rtl/prio_pick8.sv - combinational picker: fixed highest-index or round-robin after start
module prio_pick8 (
    input  logic [7:0] vec,
    input  logic [2:0] start,
    input  logic       rr,
    output logic [2:0] sel,
    output logic       any
);

    logic [2:0] pos;

    always_comb begin
        sel = 3'd0;
        pos = 3'd0;
        any = |vec;
        if (rr) begin
            // Scan downward in distance so the nearest bit after start wins.
            for (int k = 7; k >= 0; k--) begin
                pos = start + 3'(k) + 3'd1;
                if (vec[pos]) begin
                    sel = pos;
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) begin
                    sel = 3'(i);
                end
            end
        end
    end

endmodule

// File: rtl/req_encoder_8to3.sv
// rtl/req_encoder_8to3.sv - sticky request collector serving one index per valid/ready handshake
module req_encoder_8to3
    import enc_pkg::*;
#(
    parameter int N_IN_P  = N_IN,
    parameter int IDX_W_P = IDX_W,
    parameter int RR_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_IN_P-1:0]   req_i,
    input  logic [N_IN_P-1:0]   mask_i,
    output logic [IDX_W_P-1:0]  idx_o,
    output logic [N_IN_P-1:0]   onehot_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [N_IN_P-1:0]   pending_o,
    output logic                drop_o
);

    state_e               state_q, state_d;
    logic [IDX_W_P-1:0]   idx_q, idx_d;
    logic [IDX_W_P-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W_P-1:0]   start, sel;
    logic [N_IN_P-1:0]    pending_q, pending_d;
    logic [N_IN_P-1:0]    clr, elig;
    logic                 valid_q, valid_d;
    logic                 drop_q, drop_d;
    logic                 hs, any;

    always_comb begin
        hs        = valid_q & ready_i;
        clr       = hs ? onehot8(idx_q) : '0;
        pending_d = (pending_q & ~clr) | req_i;
        elig      = pending_q & mask_i & ~clr;
        drop_d    = |(req_i & pending_q & ~clr);
        // On a grant the pointer moves this edge, so the back-to-back pick starts after it.
        start     = hs ? idx_q : rr_ptr_q;
    end

    prio_pick8 u_pick (
        .vec   (elig),
        .start (start),
        .rr    (RR_MODE != 0),
        .sel   (sel),
        .any   (any)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    idx_d   = sel;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // Without ready the offer is frozen regardless of new requests or mask changes.
                if (ready_i) begin
                    rr_ptr_d = idx_q;
                    if (any) begin
                        idx_d = sel;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            rr_ptr_q  <= 3'd7;
            pending_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    assign idx_o     = idx_q;
    assign valid_o   = valid_q;
    assign onehot_o  = valid_q ? onehot8(idx_q) : '0;
    assign pending_o = pending_q;
    assign drop_o    = drop_q;

endmodule
